// File: rtl/onchip_memory_pipelined_if.sv
// Slave-side memory bus for onchip_memory_pipelined.
// Carries the word-addressed request, byte enables and read return.
interface onchip_memory_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   address;
  logic [DATA_W/8-1:0] byteenable;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  modport master (
    output address, byteenable, chipselect,
    output read, write, writedata,
    input  readdata, readdatavalid, waitrequest
  );

  modport slave (
    input  address, byteenable, chipselect,
    input  read, write, writedata,
    output readdata, readdatavalid, waitrequest
  );
endinterface

// File: rtl/onchip_memory_pipelined.sv
// Single-port on-chip RAM with byte enables, 1- or 2-cycle read
// pipeline, clock enable and a reset/runtime clear sweep.
module onchip_memory_pipelined #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clken,
  input  logic clear_req,
  onchip_memory_pipelined_if.slave bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              req_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic              clr_we;
  logic [DATA_W-1:0] rd_word;

  logic              p_valid;
  logic [DATA_W-1:0] p_data;
  logic              src_valid;
  logic [DATA_W-1:0] src_data;
  logic              rdv_q;
  logic [DATA_W-1:0] rdata_q;

  assign bus.waitrequest = (state == CLEAR) || !clken;

  assign req_ok = bus.chipselect && !bus.waitrequest;
  assign wr_acc = req_ok && bus.write;
  // A simultaneous read and write performs the write only.
  assign rd_acc = req_ok && bus.read && !bus.write;
  assign clr_we = clken && (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
      clr_cnt <= '0;
    end else if (clken) begin
      unique case (state)
        CLEAR: begin
          if (&clr_cnt) begin
            state   <= READY;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        READY: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  // RAM contents are never reset; only the sweep clears them.
  always_ff @(posedge clk) begin
    if (reset_n && clr_we) begin
      mem[clr_cnt] <= CLEAR_VALUE;
    end else if (reset_n && wr_acc) begin
      for (int i = 0; i < BE_W; i++) begin
        if (bus.byteenable[i]) begin
          mem[bus.address][8*i +: 8] <= bus.writedata[8*i +: 8];
        end
      end
    end
  end

  assign rd_word = mem[bus.address];

  assign src_valid = (READ_LATENCY == 2) ? p_valid : rd_acc;
  assign src_data  = (READ_LATENCY == 2) ? p_data  : rd_word;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p_valid <= 1'b0;
      p_data  <= '0;
      rdv_q   <= 1'b0;
      rdata_q <= '0;
    end else if (clken) begin
      p_valid <= rd_acc;
      if (rd_acc) begin
        p_data <= rd_word;
      end
      rdv_q <= src_valid;
      if (src_valid) begin
        rdata_q <= src_data;
      end
    end
  end

  // A stalled result stays queued and strobes on the next enabled cycle.
  assign bus.readdatavalid = rdv_q && clken;
  assign bus.readdata      = rdata_q;

endmodule

// File: tb/tb_onchip_memory_pipelined.sv
// Scoreboard bench: latency-1 and latency-2 instances share one
// stimulus stream; each has its own expected-read queue.
module tb_onchip_memory_pipelined;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clken = 1'b1;
  logic clear_req = 1'b0;

  always #5 clk = ~clk;

  onchip_memory_pipelined_if #(.DATA_W(32), .ADDR_W(10)) b1 ();
  onchip_memory_pipelined_if #(.DATA_W(32), .ADDR_W(10)) b2 ();

  assign b2.address    = b1.address;
  assign b2.byteenable = b1.byteenable;
  assign b2.chipselect = b1.chipselect;
  assign b2.read       = b1.read;
  assign b2.write      = b1.write;
  assign b2.writedata  = b1.writedata;

  onchip_memory_pipelined #(.READ_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .clear_req(clear_req), .bus(b1)
  );

  onchip_memory_pipelined #(.READ_LATENCY(2)) u2 (
    .clk(clk), .reset_n(reset_n), .clken(clken),
    .clear_req(clear_req), .bus(b2)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  logic [31:0] mdl [1024];
  int          ccnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          n1;
  int          n2;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) if (clken) ccnt <= ccnt + 1;

  always @(negedge clk) begin : mon1
    exp_t e;
    if (b1.readdatavalid) begin
      if (q1.size() == 0) begin
        chk("rdv1_unexp", {63'b0, b1.readdatavalid}, 0);
      end else begin
        e = q1.pop_front();
        chk("rd1_data", b1.readdata, e.data);
        chk("rd1_lat", ccnt, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (b2.readdatavalid) begin
      if (q2.size() == 0) begin
        chk("rdv2_unexp", {63'b0, b2.readdatavalid}, 0);
      end else begin
        e = q2.pop_front();
        chk("rd2_data", b2.readdata, e.data);
        chk("rd2_lat", ccnt, e.due);
      end
    end
  end

  task automatic idle();
    b1.chipselect = 1'b0;
    b1.read       = 1'b0;
    b1.write      = 1'b0;
    b1.address    = '0;
    b1.writedata  = '0;
    b1.byteenable = '0;
    clear_req     = 1'b0;
    clken         = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input bit r, input bit w,
                    input logic [9:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be,
                    input bit clr);
    b1.chipselect = 1'b1;
    b1.read       = r;
    b1.write      = w;
    b1.address    = a;
    b1.writedata  = d;
    b1.byteenable = be;
    clear_req     = clr;
    if (r && !w) begin
      q1.push_back(exp_t'{mdl[a], ccnt + 1});
      q2.push_back(exp_t'{mdl[a], ccnt + 2});
    end
    if (w) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mdl[a][8*i +: 8] = d[8*i +: 8];
    end
    tick();
    idle();
  endtask

  task automatic rd(input logic [9:0] a);
    op(1'b1, 1'b0, a, 32'h0, 4'h0, 1'b0);
  endtask

  task automatic wr(input logic [9:0] a,
                    input logic [31:0] d,
                    input logic [3:0] be);
    op(1'b0, 1'b1, a, d, be, 1'b0);
  endtask

  // kind 1 pulses clear_req, kind 2 pulses reset_n, at busy cycle 'at'.
  task automatic wait_ready(input int at, input int kind,
                            output int c1, output int c2);
    int it;
    c1 = 0;
    c2 = 0;
    it = 0;
    @(negedge clk);
    while ((b1.waitrequest || b2.waitrequest) && it < 5000) begin
      it++;
      if (b1.waitrequest) c1++;
      if (b2.waitrequest) c2++;
      clear_req = (kind == 1) && (c1 == at);
      reset_n   = !((kind == 2) && (c1 == at));
      @(negedge clk);
    end
    clear_req = 1'b0;
    reset_n   = 1'b1;
    tick();
  endtask

  task automatic clear_mdl();
    foreach (mdl[i]) mdl[i] = '0;
  endtask

  initial begin
    idle();
    clear_mdl();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wait1", b1.waitrequest, 1);
    chk("rst_wait2", b2.waitrequest, 1);
    chk("rst_rdv1", b1.readdatavalid, 0);
    chk("rst_rdv2", b2.readdatavalid, 0);
    chk("rst_rdata1", b1.readdata, 0);
    chk("rst_rdata2", b2.readdata, 0);
    tick();
    reset_n = 1'b1;
    wait_ready(0, 0, n1, n2);
    chk("init_sweep1", n1, 1024);
    chk("init_sweep2", n2, 1024);

    rd(10'h000);
    rd(10'h3FF);
    rd(10'h123);

    wr(10'h005, 32'hDEADBEEF, 4'b0101);
    rd(10'h005);
    wr(10'h005, 32'hFFFFFFFF, 4'b0000);
    rd(10'h005);
    wr(10'h006, 32'hA5A5A5A5, 4'b1010);
    rd(10'h006);

    for (int i = 1; i <= 4; i++)
      wr(10'(i), 32'h11 * i, 4'hF);
    for (int i = 1; i <= 4; i++)
      rd(10'(i));
    repeat (3) tick();

    wr(10'h010, 32'hCAFE0010, 4'hF);
    rd(10'h010);
    clken = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_wait", b1.waitrequest, 1);
      tick();
    end
    clken = 1'b1;
    repeat (3) tick();

    clken     = 1'b0;
    clear_req = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("clr_gated", b1.waitrequest, 0);
    tick();

    wr(10'h030, 32'h11111111, 4'hF);
    rd(10'h030);
    wr(10'h030, 32'h22222222, 4'hF);
    rd(10'h030);

    op(1'b1, 1'b1, 10'h031, 32'h33333333, 4'hF, 1'b0);
    rd(10'h031);
    repeat (3) tick();

    wr(10'h020, 32'h00000055, 4'hF);
    op(1'b1, 1'b0, 10'h020, 32'h0, 4'h0, 1'b1);
    clear_mdl();
    wait_ready(500, 1, n1, n2);
    chk("rt_sweep1", n1, 1024);
    chk("rt_sweep2", n2, 1024);
    rd(10'h020);
    rd(10'h005);
    repeat (3) tick();

    op(1'b0, 1'b0, 10'h000, 32'h0, 4'h0, 1'b1);
    wait_ready(300, 2, n1, n2);
    chk("rst_mid1", n1, 1324);
    chk("rst_mid2", n2, 1324);
    rd(10'h031);
    rd(10'h001);

    repeat (5) tick();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
